run_presorter: RTL and testbench
================================

# run_presorter

Front-end stage of the merge tree, directly upstream of the first two-input merger and its two input FIFOs. It accepts an unsorted stream of nonzero items and sorts each group of RUN_LEN items in a small insertion buffer. It writes each group as an ascending run, followed by a 0 terminator, alternately into input FIFO 1 and input FIFO 2 of the merger.

## Interface
- DATA_WIDTH, 32, item width; value 0 is reserved as the run terminator.
- RUN_LEN, 4, items per sorted run; power of two, 2..16.

- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_data  in  DATA_WIDTH  input item.
- i_valid  in  1  i_data valid.
- o_ready  out  1  block accepts i_data this cycle.
- i_fifo_1_full  in  1  merger input FIFO 1 full.
- i_fifo_2_full  in  1  merger input FIFO 2 full.
- o_fifo_1_write  out  1  write strobe into FIFO 1.
- o_fifo_2_write  out  1  write strobe into FIFO 2.
- o_data  out  DATA_WIDTH  item to both FIFOs; qualified by the write strobes.
- o_busy  out  1  buffer non-empty, or drain in progress.

## Operation
- The state machine has three states: FILL, DRAIN, TERM.
- Registers:
  - sorted buffer buf[0..RUN_LEN-1];
  - count, width $clog2(RUN_LEN)+1;
  - rd_idx, same width as count;
  - sel, 0 = FIFO 1, 1 = FIFO 2.
- FILL:
  - o_ready = (count < RUN_LEN).
  - An accept is i_valid && o_ready at a rising edge.
  - A nonzero item is inserted ascending in one cycle, then count++.
  - Insertion is stable: a new item goes after existing equal items.
  - When count reaches RUN_LEN → DRAIN, rd_idx = 0.
- Flush: an accepted 0 is never stored.
  - If count > 0 → DRAIN (partial run).
  - If count == 0 → the 0 is consumed and nothing happens.
- DRAIN:
  - o_data = buf[rd_idx].
  - The write strobe for sel asserts when that FIFO is not full; the other strobe stays 0.
  - Each write does rd_idx++.
  - After the write of index count-1 → TERM.
- TERM:
  - o_data = 0; strobe for sel asserts when not full.
  - On that write: sel toggles, count = 0, → FILL.
- Outputs are driven from state and registers; the only combinational input paths are the full flags into the strobes.
- o_ready = 0 in DRAIN and TERM.
- o_busy = (state != FILL) || (count != 0).
- Each strobe is gated by its own full flag, so overrun is impossible.
- Never more than one strobe is high in any cycle.

## Timing
- Reset (async assert) forces:
  - o_fifo_1_write = o_fifo_2_write = 0, o_data = 0, o_ready = 0, o_busy = 0;
  - state = FILL, count = 0, sel = 0.
- First cycle after release: o_ready = 1.
- Accept latency: 1 item per cycle in FILL.
- The first run write is asserted in the cycle after the accept that completes the run, or after the flushing 0.
- Without backpressure:
  - a run of n items occupies n+1 consecutive write cycles;
  - full throughput is RUN_LEN items per 2·RUN_LEN+1 cycles.
- Backpressure: while the selected full flag is high, the strobe stays 0 and o_data, rd_idx and state are held. Writing resumes the cycle after full deasserts.
- Full on the non-selected FIFO has no effect.
- Reset mid-DRAIN or mid-TERM:
  - strobes drop immediately and the partial run is discarded, with no terminator;
  - the next run goes to FIFO 1.
- Source must hold i_data/i_valid while o_ready = 0.

## Structure
- Shared package bonsai_pkg holds:
  - DATA_WIDTH default;
  - TERMINATOR = 0;
  - presorter state enum {FILL, DRAIN, TERM}.
- Sub-module presorter_insert_buf holds:
  - the register array;
  - parallel compare plus shift-insert;
  - read mux on rd_idx.
- The top-level holds the FSM, count, sel, strobes and ready.

## Test plan
1. Reset, feed 7,3,5,1 → FIFO 1 gets 1,3,5,7,0 on 5 consecutive cycles; o_fifo_2_write never asserts; o_ready low during those 5 cycles.
2. Feed 4,2,8,6 then 9,9,1,2 → FIFO 2 gets 2,4,6,8,0, then FIFO 1 gets 1,2,9,9,0; the equal 9s are written back-to-back.
3. Flush: feed 5,2,0 → selected FIFO gets 2,5,0. Then feed a lone 0 → no write strobe, o_busy stays 0, sel unchanged.
4. Backpressure: hold i_fifo_1_full high for 3 cycles after the second write of run 3,1,4,2 → strobe low and o_data = 3 held for 3 cycles; then 3,4,0 follow. A full asserted on FIFO 2 at the same time is ignored.
5. Assert i_rst_n low mid-DRAIN after 2 writes → strobes and o_ready drop in the same cycle. After release, feed 8,7,6,5 → FIFO 1 gets 5,6,7,8,0.
6. Toggle i_valid randomly during FILL with items 10,40,20,30 → accepts only when i_valid && o_ready; output 10,20,30,40,0; no item lost or duplicated.

Source files
------------

// File: rtl/bonsai_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bonsai_pkg : shared constants and types for the merge-tree front end
// Revision   : 1.0
// ---------------------------------------------------------------------------
package bonsai_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int TERMINATOR         = 0;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        TERM  = 2'd2
    } presorter_state_e;

endpackage
`default_nettype wire

// File: rtl/presorter_insert_buf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// presorter_insert_buf : ascending insertion buffer with stable shift-insert
// Revision             : 1.0
// ---------------------------------------------------------------------------
module presorter_insert_buf
    import bonsai_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RUN_LEN    = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_ins_en,
    input  logic [DATA_WIDTH-1:0]      i_din,
    input  logic [$clog2(RUN_LEN):0]   i_count,
    input  logic [$clog2(RUN_LEN)-1:0] i_rd_idx,
    output logic [DATA_WIDTH-1:0]      o_rd_data
);

    localparam int CNT_W = $clog2(RUN_LEN) + 1;

    logic [DATA_WIDTH-1:0] mem_q [RUN_LEN];
    logic [DATA_WIDTH-1:0] mem_d [RUN_LEN];
    logic [RUN_LEN-1:0]    w_ins;

    // w_ins marks the slots from the insertion point up to count; strict '>'
    // keeps the new item behind any equal items already stored.
    genvar i;
    generate
        for (i = 0; i < RUN_LEN; i++) begin : g_slot
            assign w_ins[i] = ((CNT_W'(i) < i_count) && (mem_q[i] > i_din))
                              || (CNT_W'(i) == i_count);
            if (i == 0) begin : g_first
                assign mem_d[i] = w_ins[i] ? i_din : mem_q[i];
            end else begin : g_rest
                assign mem_d[i] = !w_ins[i]    ? mem_q[i]   :
                                  w_ins[i-1]   ? mem_q[i-1] : i_din;
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < RUN_LEN; k++) mem_q[k] <= '0;
        end else if (i_ins_en) begin
            for (int k = 0; k < RUN_LEN; k++) mem_q[k] <= mem_d[k];
        end
    end

    assign o_rd_data = mem_q[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/run_presorter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// run_presorter : sorts groups of RUN_LEN items into 0-terminated ascending
//                 runs, alternating between the two merger input FIFOs
// Revision      : 1.0
// ---------------------------------------------------------------------------
module run_presorter
    import bonsai_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int RUN_LEN    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_fifo_1_full,
    input  logic                  i_fifo_2_full,
    output logic                  o_fifo_1_write,
    output logic                  o_fifo_2_write,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy
);

    localparam int CNT_W = $clog2(RUN_LEN) + 1;
    localparam int IDX_W = $clog2(RUN_LEN);

    presorter_state_e   state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   rd_idx_q, rd_idx_d;
    logic               sel_q, sel_d;
    logic               run_q;
    logic               w_accept, w_sel_free, w_ins_en;
    logic [DATA_WIDTH-1:0] w_rd_data;

    presorter_insert_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .RUN_LEN    (RUN_LEN)
    ) u_buf (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_ins_en   (w_ins_en),
        .i_din      (i_data),
        .i_count    (count_q),
        .i_rd_idx   (rd_idx_q[IDX_W-1:0]),
        .o_rd_data  (w_rd_data)
    );

    // run_q keeps o_ready low while reset is held, without a combinational
    // path from the reset pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= FILL;
            count_q  <= '0;
            rd_idx_q <= '0;
            sel_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_idx_q <= rd_idx_d;
            sel_q    <= sel_d;
            run_q    <= 1'b1;
        end
    end

    assign o_ready    = run_q && (state_q == FILL) && (count_q < CNT_W'(RUN_LEN));
    assign w_accept   = i_valid && o_ready;
    assign w_sel_free = sel_q ? !i_fifo_2_full : !i_fifo_1_full;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_idx_d = rd_idx_q;
        sel_d    = sel_q;
        w_ins_en = 1'b0;
        case (state_q)
            FILL: begin
                if (w_accept) begin
                    if (i_data == DATA_WIDTH'(TERMINATOR)) begin
                        if (count_q != '0) begin
                            state_d  = DRAIN;
                            rd_idx_d = '0;
                        end
                    end else begin
                        w_ins_en = 1'b1;
                        count_d  = count_q + CNT_W'(1);
                        if (count_d == CNT_W'(RUN_LEN)) begin
                            state_d  = DRAIN;
                            rd_idx_d = '0;
                        end
                    end
                end
            end
            DRAIN: begin
                if (w_sel_free) begin
                    rd_idx_d = rd_idx_q + CNT_W'(1);
                    if (rd_idx_q == count_q - CNT_W'(1)) state_d = TERM;
                end
            end
            TERM: begin
                if (w_sel_free) begin
                    sel_d   = !sel_q;
                    count_d = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign o_fifo_1_write = (state_q != FILL) && !sel_q && !i_fifo_1_full;
    assign o_fifo_2_write = (state_q != FILL) &&  sel_q && !i_fifo_2_full;
    assign o_data         = (state_q == DRAIN) ? w_rd_data : '0;
    assign o_busy         = (state_q != FILL) || (count_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_run_presorter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_run_presorter : directed self-checking bench for run_presorter
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_run_presorter;

    localparam int DW = 32;
    localparam int RL = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din   = '0;
    logic          valid = 1'b0;
    logic          f1    = 1'b0;
    logic          f2    = 1'b0;
    logic          ready, w1, w2, busy;
    logic [DW-1:0] dout;

    int total = 0;
    int bad   = 0;

    run_presorter #(.DATA_WIDTH(DW), .RUN_LEN(RL)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_data         (din),
        .i_valid        (valid),
        .o_ready        (ready),
        .i_fifo_1_full  (f1),
        .i_fifo_2_full  (f2),
        .o_fifo_1_write (w1),
        .o_fifo_2_write (w2),
        .o_data         (dout),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Present one item and hold it until accepted (bounded wait).
    task automatic feed(input logic [DW-1:0] v);
        int n = 0;
        din   = v;
        valid = 1'b1;
        forever begin
            @(negedge clk);
            if (ready) break;
            n++;
            if (n > 50) begin
                total++; bad++;
                $display("FAIL feed_timeout item=%0d ready=%0b required 1", v, ready);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (w1 !== 1'b0 || w2 !== 1'b0 || dout !== '0 || ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold w1=%0b w2=%0b data=%0d ready=%0b busy=%0b required all 0",
                     w1, w2, dout, ready, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release ready=%0b busy=%0b required ready=1 busy=0", ready, busy);
        end
    endtask

    task automatic test_basic_run();
        logic [DW-1:0] exp [$] = '{1, 3, 5, 7, 0};
        feed(7); feed(3); feed(5); feed(1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (w1 !== 1'b1 || w2 !== 1'b0 || dout !== exp[k] || ready !== 1'b0) begin
                bad++;
                $display("FAIL basic_wr%0d w1=%0b w2=%0b data=%0d ready=%0b required 1/0/%0d/0",
                         k, w1, w2, dout, ready, exp[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] expa [$] = '{2, 4, 6, 8, 0};
        logic [DW-1:0] expb [$] = '{1, 2, 9, 9, 0};
        feed(4); feed(2); feed(8); feed(6);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (w2 !== 1'b1 || w1 !== 1'b0 || dout !== expa[k]) begin
                bad++;
                $display("FAIL b2b_a_wr%0d w1=%0b w2=%0b data=%0d required 0/1/%0d",
                         k, w1, w2, dout, expa[k]);
            end
            @(posedge clk); #1;
        end
        feed(9); feed(9); feed(1); feed(2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (w1 !== 1'b1 || w2 !== 1'b0 || dout !== expb[k]) begin
                bad++;
                $display("FAIL b2b_b_wr%0d w1=%0b w2=%0b data=%0d required 1/0/%0d",
                         k, w1, w2, dout, expb[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] exp [$] = '{2, 5, 0};
        feed(5); feed(2); feed(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if (w2 !== 1'b1 || w1 !== 1'b0 || dout !== exp[k]) begin
                bad++;
                $display("FAIL flush_wr%0d w1=%0b w2=%0b data=%0d required 0/1/%0d",
                         k, w1, w2, dout, exp[k]);
            end
            @(posedge clk); #1;
        end
        feed(0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (w1 !== 1'b0 || w2 !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
                bad++;
                $display("FAIL lone_zero%0d w1=%0b w2=%0b busy=%0b ready=%0b required 0/0/0/1",
                         k, w1, w2, busy, ready);
            end
            @(posedge clk); #1;
        end
    endtask

    // Also confirms sel was left unchanged by the lone 0: this run lands in FIFO 1.
    task automatic test_backpressure();
        logic [DW-1:0] exp [$] = '{1, 2, 3, 4, 0};
        feed(3); feed(1); feed(4); feed(2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                f1 = 1'b1; f2 = 1'b1;
                for (int h = 0; h < 3; h++) begin
                    @(negedge clk);
                    total++;
                    if (w1 !== 1'b0 || w2 !== 1'b0 || dout !== 32'd3 || busy !== 1'b1) begin
                        bad++;
                        $display("FAIL bp_hold%0d w1=%0b w2=%0b data=%0d busy=%0b required 0/0/3/1",
                                 h, w1, w2, dout, busy);
                    end
                    @(posedge clk); #1;
                end
                f1 = 1'b0; f2 = 1'b0;
            end
            @(negedge clk);
            total++;
            if (w1 !== 1'b1 || w2 !== 1'b0 || dout !== exp[k]) begin
                bad++;
                $display("FAIL bp_wr%0d w1=%0b w2=%0b data=%0d required 1/0/%0d",
                         k, w1, w2, dout, exp[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [DW-1:0] exp [$] = '{5, 6, 7, 8, 0};
        feed(9); feed(8); feed(7); feed(6);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (w2 !== 1'b1 || w1 !== 1'b0 || dout !== DW'(k + 6)) begin
                bad++;
                $display("FAIL mid_wr%0d w1=%0b w2=%0b data=%0d required 0/1/%0d",
                         k, w1, w2, dout, k + 6);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (w1 !== 1'b0 || w2 !== 1'b0 || ready !== 1'b0 || busy !== 1'b0 || dout !== '0) begin
            bad++;
            $display("FAIL mid_reset w1=%0b w2=%0b ready=%0b busy=%0b data=%0d required all 0",
                     w1, w2, ready, busy, dout);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        feed(8); feed(7); feed(6); feed(5);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (w1 !== 1'b1 || w2 !== 1'b0 || dout !== exp[k]) begin
                bad++;
                $display("FAIL post_reset_wr%0d w1=%0b w2=%0b data=%0d required 1/0/%0d",
                         k, w1, w2, dout, exp[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_valid_toggle();
        logic [DW-1:0] items [$] = '{10, 40, 20, 30};
        logic [DW-1:0] exp   [$] = '{10, 20, 30, 40, 0};
        for (int i = 0; i < 4; i++) begin
            logic acc;
            int   n;
            acc = 1'b0;
            n   = 0;
            din = items[i];
            while (!acc && n < 100) begin
                valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = valid && ready;
                total++;
                if (w1 !== 1'b0 || w2 !== 1'b0) begin
                    bad++;
                    $display("FAIL toggle_fill_strobe w1=%0b w2=%0b required 0/0", w1, w2);
                end
                @(posedge clk); #1;
                n++;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL toggle_timeout item=%0d accepted=0 required 1", items[i]);
            end
        end
        valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (w2 !== 1'b1 || w1 !== 1'b0 || dout !== exp[k]) begin
                bad++;
                $display("FAIL toggle_wr%0d w1=%0b w2=%0b data=%0d required 0/1/%0d",
                         k, w1, w2, dout, exp[k]);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        total++;
        if (w1 !== 1'b0 || w2 !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL toggle_idle w1=%0b w2=%0b busy=%0b required 0/0/0", w1, w2, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_back_to_back();
        test_flush();
        test_backpressure();
        test_reset_mid_drain();
        test_valid_toggle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
